// File: rtl/axi4_stream_packetizer.sv
// axi4_stream_packetizer
// Frames a raw word stream into AXI4-Stream packets from per-packet commands
// (byte length, tid, tdest, tuser). Generates tlast and tkeep/tstrb for the
// partial final beat.
// Optional feature macro: AXIS_PKTZ_OUT_REG_EN
//   defined   -> 2-entry skid buffer, all axis outputs registered, 1-cycle latency
//   undefined -> combinational pass-through from din to axis, zero latency
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for a command; cmd_ready high once out of reset
// S_STREAM | moving din words to the stream; rem = bytes still to send

module axi4_stream_packetizer #(
    parameter type         tdata_t = logic [31:0],
    parameter type         tid_t   = logic [7:0],
    parameter type         tdest_t = logic [7:0],
    parameter type         tuser_t = logic [31:0],
    parameter int unsigned LEN_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [LEN_W-1:0]            cmd_len,
    input  tid_t                        cmd_id,
    input  tdest_t                      cmd_dest,
    input  tuser_t                      cmd_user,
    input  logic                        din_valid,
    output logic                        din_ready,
    input  tdata_t                      din_data,
    output logic                        axis_tvalid,
    input  logic                        axis_tready,
    output tdata_t                      axis_tdata,
    output logic [$bits(tdata_t)/8-1:0] axis_tkeep,
    output logic [$bits(tdata_t)/8-1:0] axis_tstrb,
    output logic                        axis_tlast,
    output tid_t                        axis_tid,
    output tdest_t                      axis_tdest,
    output tuser_t                      axis_tuser,
    output logic                        pkt_done,
    output logic                        err_zero_len
);

    localparam int unsigned BYTES = $bits(tdata_t) / 8;
    localparam int unsigned RW    = $clog2(BYTES) + 1;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    logic [0:0]       state_q;
    logic [LEN_W-1:0] rem_q;
    tid_t             id_q;
    tdest_t           dest_q;
    tuser_t           user_q;
    logic             live_q;

    logic             streaming;
    logic             cmd_hs;
    logic             din_hs;
    logic             is_last;
    logic             done_set;
    logic [BYTES-1:0] beat_keep;

    assign streaming = (state_q == S_STREAM);
    // live_q holds cmd_ready low for the first cycle after reset release
    assign cmd_ready = live_q && !streaming;
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign din_hs    = din_valid && din_ready;
    assign is_last   = (rem_q <= LEN_W'(BYTES));
    // only consulted when rem <= BYTES, so the low RW bits hold the full count
    assign beat_keep = is_last ? ~({BYTES{1'b1}} << rem_q[RW-1:0]) : {BYTES{1'b1}};

    // Command acceptance and per-beat byte accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            id_q    <= '0;
            dest_q  <= '0;
            user_q  <= '0;
            live_q  <= 1'b0;
        end else begin
            live_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (cmd_hs && (cmd_len != '0)) begin
                        state_q <= S_STREAM;
                        rem_q   <= cmd_len;
                        id_q    <= cmd_id;
                        dest_q  <= cmd_dest;
                        user_q  <= cmd_user;
                    end
                end
                default: begin
                    if (din_hs) begin
                        rem_q <= rem_q - LEN_W'(BYTES);
                        if (is_last) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Single-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_done     <= 1'b0;
            err_zero_len <= 1'b0;
        end else begin
            pkt_done     <= done_set;
            err_zero_len <= cmd_hs && (cmd_len == '0);
        end
    end

`ifdef AXIS_PKTZ_OUT_REG_EN
    typedef struct packed {
        tdata_t           data;
        logic [BYTES-1:0] keep;
        logic             last;
        tid_t             id;
        tdest_t           dest;
        tuser_t           user;
    } beat_t;

    beat_t beat;
    beat_t s0_q;
    beat_t s1_q;
    logic  v0_q;
    logic  v1_q;
    logic  pop;

    assign beat = '{data: din_data, keep: beat_keep, last: is_last,
                    id: id_q, dest: dest_q, user: user_q};
    // ready depends only on flops, so tready never reaches din_ready
    assign din_ready = streaming && !v1_q;
    assign pop       = v0_q && axis_tready;
    assign done_set  = pop && s0_q.last;

    // Skid buffer: s0 drives the stream, s1 catches the beat in flight on a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q <= '0;
            s1_q <= '0;
            v0_q <= 1'b0;
            v1_q <= 1'b0;
        end else begin
            case ({din_hs, pop})
                2'b10: begin
                    if (!v0_q) begin
                        s0_q <= beat;
                        v0_q <= 1'b1;
                    end else begin
                        s1_q <= beat;
                        v1_q <= 1'b1;
                    end
                end
                2'b01: begin
                    s0_q <= s1_q;
                    v0_q <= v1_q;
                    v1_q <= 1'b0;
                end
                2'b11: begin
                    if (v1_q) begin
                        s0_q <= s1_q;
                        s1_q <= beat;
                    end else begin
                        s0_q <= beat;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign axis_tvalid = v0_q;
    assign axis_tdata  = s0_q.data;
    assign axis_tkeep  = s0_q.keep;
    assign axis_tstrb  = s0_q.keep;
    assign axis_tlast  = s0_q.last;
    assign axis_tid    = s0_q.id;
    assign axis_tdest  = s0_q.dest;
    assign axis_tuser  = s0_q.user;
`else
    assign din_ready   = streaming && axis_tready;
    assign done_set    = din_hs && is_last;

    assign axis_tvalid = streaming && din_valid;
    assign axis_tdata  = streaming ? din_data  : '0;
    assign axis_tkeep  = streaming ? beat_keep : '0;
    assign axis_tstrb  = streaming ? beat_keep : '0;
    assign axis_tlast  = streaming && is_last;
    assign axis_tid    = streaming ? id_q   : '0;
    assign axis_tdest  = streaming ? dest_q : '0;
    assign axis_tuser  = streaming ? user_q : '0;
`endif

endmodule

// File: tb/tb_axi4_stream_packetizer.sv
// Bench for axi4_stream_packetizer (4-byte words). A reference model turns each
// command into the expected beat list; a monitor scores every output handshake.
module tb_axi4_stream_packetizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_len;
    logic [7:0]  cmd_id;
    logic [7:0]  cmd_dest;
    logic [31:0] cmd_user;
    logic        din_valid;
    logic        din_ready;
    logic [31:0] din_data;
    logic        axis_tvalid;
    logic        axis_tready;
    logic [31:0] axis_tdata;
    logic [3:0]  axis_tkeep;
    logic [3:0]  axis_tstrb;
    logic        axis_tlast;
    logic [7:0]  axis_tid;
    logic [7:0]  axis_tdest;
    logic [31:0] axis_tuser;
    logic        pkt_done;
    logic        err_zero_len;

    always #5 clk = ~clk;

    axi4_stream_packetizer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_id(cmd_id), .cmd_dest(cmd_dest), .cmd_user(cmd_user),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
        .axis_tvalid(axis_tvalid), .axis_tready(axis_tready), .axis_tdata(axis_tdata),
        .axis_tkeep(axis_tkeep), .axis_tstrb(axis_tstrb), .axis_tlast(axis_tlast),
        .axis_tid(axis_tid), .axis_tdest(axis_tdest), .axis_tuser(axis_tuser),
        .pkt_done(pkt_done), .err_zero_len(err_zero_len)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [7:0]  id;
        logic [7:0]  dest;
        logic [31:0] user;
    } beat_t;

    typedef struct {
        int          len;
        logic [7:0]  id;
        logic [7:0]  dest;
        logic [31:0] user;
        logic [31:0] base;
        int          beats;
        logic [3:0]  last_keep;
    } vec_t;

    beat_t       exp_q[$];
    logic [31:0] word_q[$];

    int tests = 0;
    int fails = 0;
    int pkt_done_cnt = 0;
    int err_cnt = 0;
    int tvalid_cycles = 0;
    int hs_cnt = 0;
    int cur_beats = 0;
    int last_pkt_beats = 0;
    logic [3:0] last_keep = '0;
    int tready_mode = 0;
    bit din_rand = 0;
    bit din_hs_seen = 0;
    bit prev_stall = 0;
    logic [88:0] prev_pay;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] k);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{k[b]}};
        return m;
    endfunction

    // Monitor: samples on the falling edge, so the values seen here are the ones
    // the next rising edge will act on.
    always @(negedge clk) begin
        din_hs_seen = din_valid && din_ready;
        if (!rst_n) begin
            prev_stall = 0;
            cur_beats  = 0;
        end else begin
            logic [88:0] pay;
            pay = {axis_tdata, axis_tkeep, axis_tstrb, axis_tlast, axis_tid, axis_tdest, axis_tuser};
            if (prev_stall)
                check("stable_while_stalled", 128'({axis_tvalid, pay}), 128'({1'b1, prev_pay}));
            if (pkt_done) pkt_done_cnt++;
            if (err_zero_len) err_cnt++;
            if (axis_tvalid) tvalid_cycles++;
            if (axis_tvalid && axis_tready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 128'(1), 128'(0));
                end else begin
                    beat_t e;
                    logic [31:0] m;
                    e = exp_q.pop_front();
                    m = byte_mask(e.keep);
                    check("beat", 128'({axis_tdata & m, axis_tkeep, axis_tstrb, axis_tlast,
                                        axis_tid, axis_tdest, axis_tuser}),
                                  128'({e.data & m, e.keep, e.keep, e.last, e.id, e.dest, e.user}));
                end
                if (axis_tlast) begin
                    last_pkt_beats = cur_beats + 1;
                    last_keep      = axis_tkeep;
                    cur_beats      = 0;
                end else begin
                    cur_beats++;
                end
            end
            prev_stall = axis_tvalid && !axis_tready;
            prev_pay   = pay;
        end
    end

    // Output back-pressure: 0 always ready, 1 toggling, 2 random ~75% ready
    initial begin
        axis_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (tready_mode)
                1:       axis_tready = ~axis_tready;
                2:       axis_tready = ($urandom_range(0, 3) != 0);
                default: axis_tready = 1'b1;
            endcase
        end
    end

    // Word producer: holds each word until it is consumed
    initial begin
        din_valid = 1'b0;
        din_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (din_hs_seen && word_q.size() > 0) void'(word_q.pop_front());
            if (din_valid && !din_hs_seen) begin
            end else if (word_q.size() > 0 && (!din_rand || $urandom_range(0, 4) != 0)) begin
                din_valid = 1'b1;
                din_data  = word_q[0];
            end else begin
                din_valid = 1'b0;
                din_data  = $urandom;
            end
        end
    end

    // Reference model: a packet of len bytes is ceil(len/4) words, each full
    // except the last, which carries len - 4*(beats-1) low bytes.
    task automatic model_pkt(input int len, input logic [7:0] id, input logic [7:0] dest,
                             input logic [31:0] user, input logic [31:0] base, input bit rnd);
        int nb;
        nb = (len + 3) / 4;
        for (int i = 0; i < nb; i++) begin
            beat_t b;
            int left;
            b.data = rnd ? $urandom : base * 32'(i + 1);
            left   = len - 4 * i;
            b.keep = (left >= 4) ? 4'hF : 4'((1 << left) - 1);
            b.last = (i == nb - 1);
            b.id   = id;
            b.dest = dest;
            b.user = user;
            word_q.push_back(b.data);
            exp_q.push_back(b);
        end
    endtask

    task automatic send_cmd(input int len, input logic [7:0] id, input logic [7:0] dest,
                            input logic [31:0] user);
        int n;
        bit ok;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_len   = 16'(len);
        cmd_id    = id;
        cmd_dest  = dest;
        cmd_user  = user;
        n  = 0;
        ok = 0;
        do begin
            @(negedge clk);
            ok = cmd_ready;
            n++;
        end while (!ok && n < 200);
        if (!ok) check("cmd_accept_timeout", 128'(0), 128'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_pkt(input int len, input logic [7:0] id, input logic [7:0] dest,
                           input logic [31:0] user, input logic [31:0] base, input bit rnd);
        int pd0, er0, tv0, n, limit;
        pd0 = pkt_done_cnt;
        er0 = err_cnt;
        tv0 = tvalid_cycles;
        model_pkt(len, id, dest, user, base, rnd);
        send_cmd(len, id, dest, user);
        if (len == 0) begin
            repeat (5) @(negedge clk);
            check("err_zero_len_pulses", 128'(err_cnt - er0), 128'(1));
            check("zero_len_no_tvalid", 128'(tvalid_cycles - tv0), 128'(0));
            check("zero_len_no_pkt_done", 128'(pkt_done_cnt - pd0), 128'(0));
        end else begin
            limit = ((len + 3) / 4) * 20 + 100;
            n = 0;
            while (pkt_done_cnt == pd0 && n < limit) begin
                @(negedge clk);
                n++;
            end
            repeat (2) @(negedge clk);
            check("pkt_done_pulses", 128'(pkt_done_cnt - pd0), 128'(1));
            check("expected_beats_drained", 128'(exp_q.size()), 128'(0));
            check("no_err_pulse", 128'(err_cnt - er0), 128'(0));
        end
    endtask

    vec_t vecs[8];

    initial begin
        int pd0, h0, n;
        vecs[0] = '{8,  8'h00, 8'h00, 32'h0,        32'h11111111, 2, 4'hF};
        vecs[1] = '{5,  8'h03, 8'h07, 32'hDEADBEEF, 32'h01010101, 2, 4'h1};
        vecs[2] = '{0,  8'h05, 8'h06, 32'h0,        32'h0,        0, 4'h0};
        vecs[3] = '{4,  8'h0A, 8'h0B, 32'h12345678, 32'hA5A5A5A5, 1, 4'hF};
        vecs[4] = '{1,  8'hFF, 8'h01, 32'h1,        32'h00000077, 1, 4'h1};
        vecs[5] = '{2,  8'h10, 8'h20, 32'h2,        32'h0000BEEF, 1, 4'h3};
        vecs[6] = '{3,  8'h30, 8'h40, 32'h3,        32'h00C0FFEE, 1, 4'h7};
        vecs[7] = '{11, 8'h55, 8'hAA, 32'hCAFEF00D, 32'h0F0F0F0F, 3, 4'h7};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_id    = '0;
        cmd_dest  = '0;
        cmd_user  = '0;

        #12;
        check("reset_outputs", 128'({axis_tvalid, axis_tlast, axis_tkeep, axis_tstrb, axis_tdata,
                                     axis_tid, axis_tdest, axis_tuser, cmd_ready, din_ready,
                                     pkt_done, err_zero_len}), 128'(0));
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_reset", 128'({cmd_ready, din_ready, axis_tvalid}), 128'(3'b100));

        // Directed table: always-ready sink, steady producer
        for (int v = 0; v < 8; v++) begin
            run_pkt(vecs[v].len, vecs[v].id, vecs[v].dest, vecs[v].user, vecs[v].base, 0);
            if (vecs[v].len != 0) begin
                check($sformatf("vec%0d_beats", v), 128'(last_pkt_beats), 128'(vecs[v].beats));
                check($sformatf("vec%0d_last_keep", v), 128'(last_keep), 128'(vecs[v].last_keep));
            end
        end

        // Toggling tready with a bursty producer
        tready_mode = 1;
        din_rand    = 1;
        run_pkt(12, 8'h21, 8'h42, 32'h600DCAFE, 32'h0, 1);
        check("toggle_beats", 128'(last_pkt_beats), 128'(3));
        check("toggle_last_keep", 128'(last_keep), 128'(4'hF));

        // Reset in the middle of a 16-byte packet
        tready_mode = 0;
        din_rand    = 0;
        h0  = hs_cnt;
        pd0 = pkt_done_cnt;
        model_pkt(16, 8'h77, 8'h88, 32'h99999999, 32'h01000001, 0);
        send_cmd(16, 8'h77, 8'h88, 32'h99999999);
        n = 0;
        while (hs_cnt < h0 + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midpkt_two_beats_reached", 128'(hs_cnt - h0 >= 2), 128'(1));
        @(posedge clk); #2;
        rst_n = 1'b0;
        word_q.delete();
        exp_q.delete();
        din_valid = 1'b0;
        #1;
        check("midpkt_reset_outputs", 128'({axis_tvalid, axis_tlast, axis_tkeep, axis_tstrb,
                                            axis_tdata, axis_tid, axis_tdest, axis_tuser,
                                            cmd_ready, din_ready}), 128'(0));
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("midpkt_no_pkt_done", 128'(pkt_done_cnt - pd0), 128'(0));
        run_pkt(4, 8'h44, 8'h55, 32'h66666666, 32'h13572468, 0);
        check("post_reset_beats", 128'(last_pkt_beats), 128'(1));
        check("post_reset_last_keep", 128'(last_keep), 128'(4'hF));

        // 100 random packets with random stalls on both sides
        tready_mode = 2;
        din_rand    = 1;
        pd0 = pkt_done_cnt;
        for (int p = 0; p < 100; p++) begin
            int len;
            if (p == 0)           len = 65535;
            else if (p % 10 == 1) len = $urandom_range(1, 2000);
            else                  len = $urandom_range(1, 64);
            run_pkt(len, 8'($urandom), 8'($urandom), $urandom, 32'h0, 1);
            check("rand_beats", 128'(last_pkt_beats), 128'((len + 3) / 4));
        end
        check("rand_pkt_done_total", 128'(pkt_done_cnt - pd0), 128'(100));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
